// File: rtl/insn_fetch_unit.sv
// Instruction fetch: single outstanding read, one-entry output latch,
// redirect squash with in-flight discard and sticky misalignment fault.
module insn_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] INSN,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] pc_out,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_old_addr;
    logic [31:0] w_old_addr_nxt;
    logic [31:0] r_insn;
    logic [31:0] w_insn_nxt;
    logic [31:0] r_pc_out;
    logic [31:0] w_pc_out_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_fault;
    logic        w_fault_nxt;
    logic        w_redir_ok;
    logic        w_redir_bad;

    assign w_redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign w_redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_old_addr <= RESET_PC;
            r_insn     <= NOP_INSN;
            r_pc_out   <= RESET_PC;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_old_addr <= w_old_addr_nxt;
            r_insn     <= w_insn_nxt;
            r_pc_out   <= w_pc_out_nxt;
            r_valid    <= w_valid_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_old_addr_nxt = r_old_addr;
        w_insn_nxt     = r_insn;
        w_pc_out_nxt   = r_pc_out;
        w_valid_nxt    = r_valid;
        w_fault_nxt    = r_fault;
        if (w_redir_bad) begin
            w_state_nxt = S_HALT;
            w_fault_nxt = 1'b1;
            w_valid_nxt = 1'b0;
            w_insn_nxt  = NOP_INSN;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_REQ;
                    if (w_redir_ok) w_pc_nxt = redirect_pc;
                end
                S_REQ: begin
                    if (w_redir_ok) begin
                        w_pc_nxt = redirect_pc;
                        // Read still in flight: remember its address until acked
                        if (!mem_ack) begin
                            w_old_addr_nxt = r_pc;
                            w_state_nxt    = S_DISCARD;
                        end
                    end else if (mem_ack) begin
                        w_insn_nxt   = mem_rdata;
                        w_pc_out_nxt = r_pc;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_redir_ok) begin
                        w_pc_nxt    = redirect_pc;
                        w_valid_nxt = 1'b0;
                        w_insn_nxt  = NOP_INSN;
                        w_state_nxt = S_REQ;
                    end else if (insn_ready) begin
                        w_pc_nxt    = r_pc + 32'd4;
                        w_valid_nxt = 1'b0;
                        w_insn_nxt  = NOP_INSN;
                        w_state_nxt = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (w_redir_ok) w_pc_nxt = redirect_pc;
                    if (mem_ack) w_state_nxt = S_REQ;
                end
                S_HALT: begin
                    w_state_nxt = S_HALT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = (r_state == S_REQ) || (r_state == S_DISCARD);
    assign mem_addr   = (r_state == S_DISCARD) ? r_old_addr : r_pc;
    assign INSN       = r_insn;
    assign insn_valid = r_valid;
    assign pc_out     = r_pc_out;
    assign fault      = r_fault;

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Bench for insn_fetch_unit: fetched words are queued as expectations when
// acked and popped when the unit presents them downstream.
module tb_insn_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        insn_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] INSN;
    logic        insn_valid;
    logic [31:0] pc_out;
    logic        fault;

    logic        b_mem_req;
    logic [31:0] b_mem_addr;
    logic [31:0] b_INSN;
    logic        b_insn_valid;
    logic [31:0] b_pc_out;
    logic        b_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    insn_fetch_unit dut (
        .CLK(CLK), .RST(RST),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .INSN(INSN), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .pc_out(pc_out),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fault(fault)
    );

    insn_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
        .CLK(CLK), .RST(RST),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .INSN(b_INSN), .insn_valid(b_insn_valid),
        .insn_ready(insn_ready), .pc_out(b_pc_out),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fault(b_fault)
    );

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Hold ack low for lat cycles, then pulse it for one cycle with data d.
    task automatic ack_after(input int lat, input logic [31:0] d);
        repeat (lat) tick();
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({mem_req, insn_valid, fault} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 000", {mem_req, insn_valid, fault});
        end
        n_cmp++;
        if (INSN !== NOP || pc_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_out: got %h/%h want %h/0", INSN, pc_out, NOP);
        end
        RST = 1'b0;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL idle_to_req: got %b/%h want 1/0", mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_outstanding;
        RST = 1'b1;
        tick();
        RST       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (insn_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL stale_ack: got v=%b r=%b a=%h want 0/1/0",
                     insn_valid, mem_req, mem_addr);
        end
    endtask

    task automatic test_stream;
        logic [31:0] d;
        insn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(i * 4)) begin
                n_bad++;
                $display("FAIL stream_addr: got %b/%h want 1/%h", mem_req, mem_addr, 32'(i * 4));
            end
            tick();
            n_cmp++;
            if (mem_addr !== 32'(i * 4)) begin
                n_bad++;
                $display("FAIL stream_addr_hold: got %h want %h", mem_addr, 32'(i * 4));
            end
            sbq.push_back('{pc: 32'(i * 4), insn: d});
            ack_after(1, d);
            e = sbq.pop_front();
            n_cmp++;
            if (insn_valid !== 1'b1 || INSN !== e.insn || pc_out !== e.pc) begin
                n_bad++;
                $display("FAIL stream_insn: got %b %h@%h want 1 %h@%h",
                         insn_valid, INSN, pc_out, e.insn, e.pc);
            end
            tick();
            n_cmp++;
            if (insn_valid !== 1'b0 || INSN !== NOP) begin
                n_bad++;
                $display("FAIL stream_pulse: got %b/%h want 0/%h", insn_valid, INSN, NOP);
            end
        end
    endtask

    task automatic test_hold;
        logic [31:0] d;
        d          = 32'hA5A5F00D;
        insn_ready = 1'b0;
        sbq.push_back('{pc: 32'h10, insn: d});
        ack_after(2, d);
        e = sbq.pop_front();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (insn_valid !== 1'b1 || INSN !== e.insn || pc_out !== e.pc || mem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stable: cyc %0d got %b %h@%h req=%b want 1 %h@%h req=0",
                         k, insn_valid, INSN, pc_out, mem_req, e.insn, e.pc);
            end
            tick();
        end
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        n_cmp++;
        if (insn_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h14) begin
            n_bad++;
            $display("FAIL hold_release: got v=%b r=%b a=%h want 0/1/14",
                     insn_valid, mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_req;
        logic [31:0] d;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h14 || insn_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL discard_addr: got r=%b a=%h v=%b want 1/14/0",
                     mem_req, mem_addr, insn_valid);
        end
        tick();
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (insn_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL discard_drop: got v=%b r=%b a=%h want 0/1/100",
                     insn_valid, mem_req, mem_addr);
        end
        d          = 32'h00500093;
        insn_ready = 1'b1;
        sbq.push_back('{pc: 32'h100, insn: d});
        ack_after(1, d);
        e = sbq.pop_front();
        n_cmp++;
        if (insn_valid !== 1'b1 || INSN !== e.insn || pc_out !== e.pc) begin
            n_bad++;
            $display("FAIL after_discard: got %b %h@%h want 1 %h@%h",
                     insn_valid, INSN, pc_out, e.insn, e.pc);
        end
        tick();
    endtask

    task automatic test_redirect_ack;
        logic [31:0] d;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        mem_ack     = 1'b1;
        mem_rdata   = 32'hBAD0BAD0;
        tick();
        redirect = 1'b0;
        mem_ack  = 1'b0;
        n_cmp++;
        if (insn_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            n_bad++;
            $display("FAIL redir_ack: got v=%b r=%b a=%h want 0/1/40",
                     insn_valid, mem_req, mem_addr);
        end
        d          = 32'h00A00113;
        insn_ready = 1'b0;
        sbq.push_back('{pc: 32'h40, insn: d});
        ack_after(1, d);
        e = sbq.pop_front();
        n_cmp++;
        if (insn_valid !== 1'b1 || INSN !== e.insn || pc_out !== e.pc) begin
            n_bad++;
            $display("FAIL redir_fetch: got %b %h@%h want 1 %h@%h",
                     insn_valid, INSN, pc_out, e.insn, e.pc);
        end
        insn_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect   = 1'b0;
        insn_ready = 1'b0;
        n_cmp++;
        if (insn_valid !== 1'b0 || INSN !== NOP || mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            n_bad++;
            $display("FAIL redir_hold: got v=%b i=%h r=%b a=%h want 0/%h/1/80",
                     insn_valid, INSN, mem_req, mem_addr, NOP);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        n_cmp++;
        if (b_mem_req !== 1'b1 || b_mem_addr !== 32'hFFFFFFFC) begin
            n_bad++;
            $display("FAIL wrap_start: got %b/%h want 1/fffffffc", b_mem_req, b_mem_addr);
        end
        d          = 32'h7FF00F93;
        insn_ready = 1'b1;
        sbq.push_back('{pc: 32'hFFFFFFFC, insn: d});
        ack_after(1, d);
        e = sbq.pop_front();
        n_cmp++;
        if (b_insn_valid !== 1'b1 || b_INSN !== e.insn || b_pc_out !== e.pc) begin
            n_bad++;
            $display("FAIL wrap_insn: got %b %h@%h want 1 %h@%h",
                     b_insn_valid, b_INSN, b_pc_out, e.insn, e.pc);
        end
        tick();
        insn_ready = 1'b0;
        n_cmp++;
        if (b_mem_req !== 1'b1 || b_mem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_addr: got %b/%h want 1/0", b_mem_req, b_mem_addr);
        end
    endtask

    task automatic test_fault;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            n_bad++;
            $display("FAIL fault_pre: got %b/%h want 1/4", mem_req, mem_addr);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        n_cmp++;
        if (fault !== 1'b1 || mem_req !== 1'b0 || insn_valid !== 1'b0 || INSN !== NOP) begin
            n_bad++;
            $display("FAIL fault_set: got f=%b r=%b v=%b i=%h want 1/0/0/%h",
                     fault, mem_req, insn_valid, INSN, NOP);
        end
        n_cmp++;
        if (mem_addr !== 32'h4) begin
            n_bad++;
            $display("FAIL fault_pc: got %h want 4", mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (fault !== 1'b1 || mem_req !== 1'b0 || insn_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_stuck: cyc %0d got f=%b r=%b v=%b want 1/0/0",
                         k, fault, mem_req, insn_valid);
            end
            tick();
        end
        RST = 1'b1;
        tick();
        n_cmp++;
        if (fault !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_clear: got f=%b r=%b want 0/0", fault, mem_req);
        end
        RST = 1'b0;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL fault_restart: got %b/%h want 1/0", mem_req, mem_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge CLK);
        test_reset();
        test_reset_outstanding();
        test_stream();
        test_hold();
        test_redirect_req();
        test_redirect_ack();
        test_wrap();
        test_fault();
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_left: got %0d want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
